// File: rtl/mac_accum_if.sv
// Product-in / frame-result-out handshake bundle for mac_accum.
//   cfg_len   : frame length minus one, sampled on a frame's first beat
//   in_*      : product beat channel (valid/ready, 9-bit unsigned product)
//   out_*     : frame result channel (valid/ready, saturated sum + overflow flag)
// master = producer/consumer side, slave = mac_accum side.
interface mac_accum_if #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 8
);
    logic [CNT_W-1:0] cfg_len;
    logic             in_valid;
    logic             in_ready;
    logic [8:0]       in_prod;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;

    modport master (
        output cfg_len, in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    modport slave (
        input  cfg_len, in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );
endinterface

// File: rtl/mac_accum.sv
// Frame accumulator for 4x4 multiplier products.
// Sums cfg_len+1 product beats into a saturating ACC_W-bit accumulator and
// presents the sum (plus a sticky overflow flag) until the consumer takes it.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous frame abort, overrides all handshakes
//   bus        : mac_accum_if slave (beat input, result output, cfg_len)
module mac_accum #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    mac_accum_if.slave bus
);
    localparam int unsigned SUM_W   = ACC_W + 1;
    localparam int unsigned CNT_Q_W = CNT_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_Q_W-1:0] cnt;
    logic [CNT_W-1:0]   len_q;
    logic               ovf;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [SUM_W-1:0]   sum_c;
    logic               last_c;

    // One extra bit catches the carry out of the accumulator; cnt is one bit
    // wider than len_q so a full 2^CNT_W-beat frame never wraps.
    always_comb begin
        sum_c  = SUM_W'(acc) + SUM_W'(bus.in_prod);
        last_c = (cnt == CNT_Q_W'(len_q));
    end

    // Frame FSM with handshake flags registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            len_q       <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        len_q <= bus.cfg_len;
                        acc   <= ACC_W'(bus.in_prod);
                        cnt   <= CNT_Q_W'(1);
                        ovf   <= 1'b0;
                        if (bus.cfg_len == '0) begin
                            state       <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        if (sum_c[ACC_W]) begin
                            acc <= ACC_MAX;
                            ovf <= 1'b1;
                        end else begin
                            acc <= sum_c[ACC_W-1:0];
                        end
                        cnt <= cnt + CNT_Q_W'(1);
                        if (last_c) begin
                            state       <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = acc;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: a 10-bit and a 16-bit instance share one stimulus
// stream; a frame-level model predicts handshakes and saturated sums.
module tb_mac_accum;
    localparam int unsigned CNT_W = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             clear     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] cfg_len   = '0;
    logic [8:0]       in_prod   = '0;

    always #5 clk = ~clk;

    mac_accum_if #(.ACC_W(10), .CNT_W(CNT_W)) bus_a ();
    mac_accum_if #(.ACC_W(16), .CNT_W(CNT_W)) bus_b ();

    assign bus_a.cfg_len   = cfg_len;
    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_prod   = in_prod;
    assign bus_a.out_ready = out_ready;
    assign bus_b.cfg_len   = cfg_len;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_prod   = in_prod;
    assign bus_b.out_ready = out_ready;

    mac_accum #(.ACC_W(10), .CNT_W(CNT_W)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_a.slave)
    );
    mac_accum #(.ACC_W(16), .CNT_W(CNT_W)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_b.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_sum(input int total, input int w);
        int mx = (1 << w) - 1;
        return (total > mx) ? mx : total;
    endfunction

    function automatic int sat_flag(input int total, input int w);
        int mx = (1 << w) - 1;
        return (total > mx) ? 1 : 0;
    endfunction

    // Frame-level model: collect accepted beats, total them when the frame is full.
    int  beats[$];
    int  mlen    = 0;
    int  total   = 0;
    bit  holding = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holding = 1'b0;
            beats.delete();
        end else if (clear) begin
            holding = 1'b0;
            beats.delete();
        end else if (holding) begin
            if (out_ready) begin
                holding = 1'b0;
                beats.delete();
            end
        end else if (in_valid) begin
            if (beats.size() == 0) mlen = int'(cfg_len);
            beats.push_back(int'(in_prod));
            if (beats.size() == mlen + 1) begin
                total = 0;
                foreach (beats[i]) total += beats[i];
                holding = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("a_in_ready",  int'(bus_a.in_ready),  int'(!holding));
        chk("a_out_valid", int'(bus_a.out_valid), int'(holding));
        chk("b_in_ready",  int'(bus_b.in_ready),  int'(!holding));
        chk("b_out_valid", int'(bus_b.out_valid), int'(holding));
        if (holding) begin
            chk("a_out_acc", int'(bus_a.out_acc), sat_sum(total, 10));
            chk("a_out_ovf", int'(bus_a.out_ovf), sat_flag(total, 10));
            chk("b_out_acc", int'(bus_b.out_acc), sat_sum(total, 16));
            chk("b_out_ovf", int'(bus_b.out_ovf), sat_flag(total, 16));
        end
    end

    // Offer one beat from a negedge until accepted; returns on the negedge after transfer.
    task automatic send(input int p, input int len);
        bit done = 1'b0;
        cfg_len  = CNT_W'(len);
        in_prod  = 9'(p);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus_a.in_ready) done = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic recv();
        bit done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus_a.out_valid) done = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (!done) chk("recv_timeout", 0, 1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #11;
        chk("rst_a_in_ready",  int'(bus_a.in_ready),  1);
        chk("rst_a_out_valid", int'(bus_a.out_valid), 0);
        chk("rst_a_out_acc",   int'(bus_a.out_acc),   0);
        chk("rst_b_out_ovf",   int'(bus_b.out_ovf),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame; later cfg_len values must be ignored.
        send(15, 3); send(30, 0); send(45, 7); send(225, 3);
        chk("basic_latency", int'(bus_a.out_valid), 1);
        chk("basic_a_acc",   int'(bus_a.out_acc),   315);
        chk("basic_b_acc",   int'(bus_b.out_acc),   315);
        chk("basic_a_ovf",   int'(bus_a.out_ovf),   0);
        chk("basic_model",   total,                 315);
        recv();

        // Single-beat frame with the next beat waiting on backpressure.
        send(9, 0);
        chk("single_acc", int'(bus_a.out_acc), 9);
        cfg_len = '0; in_prod = 9'(5); in_valid = 1'b1;
        chk("single_refuse0", int'(bus_a.in_ready), 0);
        @(negedge clk);
        chk("single_refuse1", int'(bus_a.in_ready), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bubble_in_ready",  int'(bus_a.in_ready),  1);
        chk("bubble_out_valid", int'(bus_a.out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("next_acc", int'(bus_b.out_acc), 5);
        recv();

        // Saturation on the 10-bit instance only; then a clean frame.
        repeat (5) send(225, 4);
        chk("sat_a_acc", int'(bus_a.out_acc), 1023);
        chk("sat_a_ovf", int'(bus_a.out_ovf), 1);
        chk("sat_b_acc", int'(bus_b.out_acc), 1125);
        chk("sat_b_ovf", int'(bus_b.out_ovf), 0);
        recv();
        send(1, 0);
        chk("post_sat_acc", int'(bus_a.out_acc), 1);
        chk("post_sat_ovf", int'(bus_a.out_ovf), 0);
        recv();

        // Input stall mid-frame, then output backpressure.
        send(100, 1);
        repeat (2) @(negedge clk);
        send(200, 1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_acc",      int'(bus_a.out_acc),  300);
            chk("bp_in_ready", int'(bus_a.in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_released", int'(bus_a.out_valid), 0);

        // Abort mid-frame with a colliding beat, then a fresh frame.
        send(50, 3); send(50, 3);
        clear = 1'b1; in_prod = 9'(99); in_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("clear_acc",      int'(bus_a.out_acc),  0);
        chk("clear_in_ready", int'(bus_a.in_ready), 1);
        send(7, 1); send(8, 1);
        chk("abort_a_acc", int'(bus_a.out_acc), 15);
        chk("abort_b_acc", int'(bus_b.out_acc), 15);
        recv();

        // Clear discards a held result.
        send(4, 0);
        chk("hold_before_clear", int'(bus_a.out_valid), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("hold_cleared_valid", int'(bus_a.out_valid), 0);
        chk("hold_cleared_acc",   int'(bus_b.out_acc),   0);

        // Asynchronous reset between edges mid-frame.
        send(10, 3); send(20, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(bus_a.out_valid), 0);
        chk("arst_a_acc",     int'(bus_a.out_acc),   0);
        chk("arst_b_acc",     int'(bus_b.out_acc),   0);
        chk("arst_in_ready",  int'(bus_a.in_ready),  1);
        @(negedge clk);
        rst_n = 1'b1;
        send(3, 0);
        chk("post_rst_acc", int'(bus_a.out_acc), 3);
        recv();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
